// File: rtl/esquema_final_pkg.sv
// Shared types and default constants for the esquema_final ATM controller.
// Build option: ESQUEMA_LOCKOUT_EN adds a failed-login lockout state.
package esquema_final_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SESSION = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [4:0] COD_OK_DEF     = 5'b10000;
  localparam logic [3:0] PIN_OK_DEF     = 4'b1001;
  localparam logic [3:0] SALDO_INIT_DEF = 4'd5;
  localparam logic [8:0] TIMEOUT_DEF    = 9'd300;

  localparam logic OP_DEP = 1'b0;
  localparam logic OP_WD  = 1'b1;

  localparam logic [1:0] FAIL_MAX = 2'd2;

endpackage

// File: rtl/saldo_alu.sv
// Combinational balance update: deposit or withdraw VAL+Cin.
// A rejected operation returns the balance unchanged with rej_o set.
module saldo_alu
  import esquema_final_pkg::*;
(
  input  logic [3:0] saldo_i,
  input  logic [3:0] val_i,
  input  logic       cin_i,
  input  logic       op_i,
  output logic [3:0] saldo_o,
  output logic       rej_o
);

  logic [4:0] sum;
  logic [4:0] need;

  always_comb begin
    sum     = {1'b0, saldo_i} + {1'b0, val_i} + {4'd0, cin_i};
    need    = {1'b0, val_i} + {4'd0, cin_i};
    saldo_o = saldo_i;
    rej_o   = 1'b0;
    if (op_i == OP_DEP) begin
      if (sum[4]) begin
        rej_o = 1'b1;
      end else begin
        saldo_o = sum[3:0];
      end
    end else begin
      if (need > {1'b0, saldo_i}) begin
        rej_o = 1'b1;
      end else begin
        saldo_o = saldo_i - need[3:0];
      end
    end
  end

endmodule

// File: rtl/esquema_final.sv
// ATM account controller: login FSM, session timer and balance registers.
// Build option: ESQUEMA_LOCKOUT_EN locks after three failed logins.
module esquema_final
  import esquema_final_pkg::*;
#(
  parameter logic [3:0] SALDO_INIT = SALDO_INIT_DEF,
  parameter logic [8:0] TIMEOUT    = TIMEOUT_DEF,
  parameter logic [4:0] COD_OK     = COD_OK_DEF,
  parameter logic [3:0] PIN_OK     = PIN_OK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PIN0,
  input  logic       PIN1,
  input  logic       PIN2,
  input  logic       PIN3,
  input  logic       COD0,
  input  logic       COD1,
  input  logic       COD2,
  input  logic       COD3,
  input  logic       COD4,
  input  logic       ENABLE,
  input  logic       Seleciona,
  input  logic       SelecionaOpcoes,
  input  logic       VAL1,
  input  logic       VAL2,
  input  logic       VAL3,
  input  logic       VAL4,
  input  logic       Cin,
  output logic       Cout,
  output logic       SALDOecra1,
  output logic       SALDOecra2,
  output logic       SALDOecra3,
  output logic       SALDOecra4,
  output logic       VALecra1,
  output logic       VALecra2,
  output logic       VALecra3,
  output logic       VALecra4,
  output logic [8:0] Tempo,
  output logic       saidaComparador
);

  state_e     state_q, state_d;
  logic [3:0] saldo_q, saldo_d;
  logic [3:0] val_q, val_d;
  logic [8:0] tempo_q, tempo_d;
  logic       cout_q, cout_d;
  logic       auth_q, auth_d;
  logic       sel_q;
`ifdef ESQUEMA_LOCKOUT_EN
  logic [1:0] fail_q, fail_d;
`endif

  logic [4:0] cod;
  logic [3:0] pin;
  logic [3:0] val;
  logic       sel_rise;
  logic       match;
  logic [3:0] alu_saldo;
  logic       alu_rej;

  assign cod      = {COD4, COD3, COD2, COD1, COD0};
  assign pin      = {PIN3, PIN2, PIN1, PIN0};
  assign val      = {VAL4, VAL3, VAL2, VAL1};
  assign sel_rise = Seleciona & ~sel_q;
  assign match    = (cod == COD_OK) && (pin == PIN_OK);

  saldo_alu u_alu (
    .saldo_i (saldo_q),
    .val_i   (val),
    .cin_i   (Cin),
    .op_i    (SelecionaOpcoes),
    .saldo_o (alu_saldo),
    .rej_o   (alu_rej)
  );

  always_comb begin
    state_d = state_q;
    saldo_d = saldo_q;
    val_d   = val_q;
    tempo_d = tempo_q;
    cout_d  = cout_q;
    auth_d  = auth_q;
`ifdef ESQUEMA_LOCKOUT_EN
    fail_d  = fail_q;
`endif
    unique case (state_q)
      IDLE: begin
        tempo_d = '0;
        auth_d  = 1'b0;
        if (ENABLE && sel_rise) begin
          if (match) begin
            state_d = SESSION;
            auth_d  = 1'b1;
`ifdef ESQUEMA_LOCKOUT_EN
            fail_d  = '0;
`endif
          end else begin
`ifdef ESQUEMA_LOCKOUT_EN
            if (fail_q == FAIL_MAX) begin
              state_d = LOCKED;
              fail_d  = '0;
            end else begin
              fail_d = fail_q + 2'd1;
            end
`endif
          end
        end
      end
      SESSION: begin
        val_d = val;
        // Leaving the session wins over a same-cycle transaction.
        if (!ENABLE || (tempo_q == TIMEOUT - 9'd1)) begin
          state_d = IDLE;
          tempo_d = '0;
          auth_d  = 1'b0;
        end else if (sel_rise) begin
          saldo_d = alu_saldo;
          cout_d  = alu_rej;
          tempo_d = '0;
        end else begin
          tempo_d = tempo_q + 9'd1;
        end
      end
      default: begin
`ifdef ESQUEMA_LOCKOUT_EN
        state_d = LOCKED;
`else
        state_d = IDLE;
`endif
        tempo_d = '0;
        auth_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      saldo_q <= SALDO_INIT;
      val_q   <= '0;
      tempo_q <= '0;
      cout_q  <= 1'b0;
      auth_q  <= 1'b0;
      sel_q   <= 1'b0;
`ifdef ESQUEMA_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      saldo_q <= saldo_d;
      val_q   <= val_d;
      tempo_q <= tempo_d;
      cout_q  <= cout_d;
      auth_q  <= auth_d;
      sel_q   <= Seleciona;
`ifdef ESQUEMA_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  assign Cout            = cout_q;
  assign SALDOecra1      = saldo_q[0];
  assign SALDOecra2      = saldo_q[1];
  assign SALDOecra3      = saldo_q[2];
  assign SALDOecra4      = saldo_q[3];
  assign VALecra1        = val_q[0];
  assign VALecra2        = val_q[1];
  assign VALecra3        = val_q[2];
  assign VALecra4        = val_q[3];
  assign Tempo           = tempo_q;
  assign saidaComparador = auth_q;

endmodule

// File: tb/tb_esquema_final.sv
// Self-checking bench for esquema_final: directed table, hand sequences
// and randomized stimulus against a behavioural account model.
module tb_esquema_final;

  localparam int SALDO_INIT = 5;
  localparam int TIMEOUT    = 300;
  localparam int COD_OK     = 16;
  localparam int PIN_OK     = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       sel = 1'b0;
  logic       op  = 1'b0;
  logic       cin = 1'b0;
  logic [4:0] cod = '0;
  logic [3:0] pin = '0;
  logic [3:0] val = '0;

  logic       cout_o;
  logic [3:0] saldo_o;
  logic [3:0] valo_o;
  logic [8:0] tempo_o;
  logic       auth_o;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int m_saldo, m_val, m_tempo, m_fails;
  bit m_cout, m_auth, m_locked, m_psel;

  always #5 clk = ~clk;

  esquema_final dut (
    .clk             (clk),
    .rst             (rst),
    .PIN0            (pin[0]),
    .PIN1            (pin[1]),
    .PIN2            (pin[2]),
    .PIN3            (pin[3]),
    .COD0            (cod[0]),
    .COD1            (cod[1]),
    .COD2            (cod[2]),
    .COD3            (cod[3]),
    .COD4            (cod[4]),
    .ENABLE          (en),
    .Seleciona       (sel),
    .SelecionaOpcoes (op),
    .VAL1            (val[0]),
    .VAL2            (val[1]),
    .VAL3            (val[2]),
    .VAL4            (val[3]),
    .Cin             (cin),
    .Cout            (cout_o),
    .SALDOecra1      (saldo_o[0]),
    .SALDOecra2      (saldo_o[1]),
    .SALDOecra3      (saldo_o[2]),
    .SALDOecra4      (saldo_o[3]),
    .VALecra1        (valo_o[0]),
    .VALecra2        (valo_o[1]),
    .VALecra3        (valo_o[2]),
    .VALecra4        (valo_o[3]),
    .Tempo           (tempo_o),
    .saidaComparador (auth_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_saldo  = SALDO_INIT;
    m_val    = 0;
    m_tempo  = 0;
    m_fails  = 0;
    m_cout   = 0;
    m_auth   = 0;
    m_locked = 0;
    m_psel   = 0;
  endtask

  task automatic model_step();
    bit rise;
    int amt;
    rise   = sel && !m_psel;
    m_psel = sel;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_locked) return;
    if (!m_auth) begin
      m_tempo = 0;
      if (en && rise) begin
        if (int'(cod) == COD_OK && int'(pin) == PIN_OK) begin
          m_auth  = 1;
          m_fails = 0;
        end else begin
          m_fails++;
`ifdef ESQUEMA_LOCKOUT_EN
          if (m_fails == 3) begin
            m_locked = 1;
            m_fails  = 0;
          end
`endif
        end
      end
      return;
    end
    m_val = int'(val);
    if (!en || m_tempo == TIMEOUT - 1) begin
      m_auth  = 0;
      m_tempo = 0;
    end else if (rise) begin
      amt     = int'(val) + int'(cin);
      m_tempo = 0;
      if (op == 1'b0) begin
        if (m_saldo + amt > 15) m_cout = 1;
        else begin
          m_saldo = m_saldo + amt;
          m_cout  = 0;
        end
      end else begin
        if (amt > m_saldo) m_cout = 1;
        else begin
          m_saldo = m_saldo - amt;
          m_cout  = 0;
        end
      end
    end else begin
      m_tempo++;
    end
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    total++;
    if (saldo_o == m_saldo[3:0] && cout_o == m_cout &&
        auth_o == m_auth && tempo_o == m_tempo[8:0] &&
        valo_o == m_val[3:0]) begin
      passed++;
    end else begin
      $display("FAIL model t=%0t: saldo %0d/%0d cout %0d/%0d auth %0d/%0d tempo %0d/%0d val %0d/%0d (got/expected)",
               $time, saldo_o, m_saldo, cout_o, m_cout, auth_o, m_auth,
               tempo_o, m_tempo, valo_o, m_val);
    end
  endtask

  task automatic press();
    sel = 1'b1;
    cycle();
    sel = 1'b0;
    cycle();
  endtask

  task automatic login();
    cod = 5'b10000;
    pin = 4'b1001;
    en  = 1'b1;
    press();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sel = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    bit         op;
    logic [3:0] val;
    bit         cin;
    int         exp_saldo;
    bit         exp_cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{"dep_9_c1",   1'b0, 4'd9,  1'b1, 15, 1'b0};
    vecs[1] = '{"dep_ovf",    1'b0, 4'd1,  1'b0, 15, 1'b1};
    vecs[2] = '{"wd_4",       1'b1, 4'd4,  1'b0, 11, 1'b0};
    vecs[3] = '{"wd_short",   1'b1, 4'd12, 1'b0, 11, 1'b1};
    vecs[4] = '{"wd_exact",   1'b1, 4'd10, 1'b1, 0,  1'b0};
    vecs[5] = '{"dep_16",     1'b0, 4'd15, 1'b1, 0,  1'b1};
    vecs[6] = '{"dep_to_15",  1'b0, 4'd15, 1'b0, 15, 1'b0};
    vecs[7] = '{"wd_need_16", 1'b1, 4'd15, 1'b1, 15, 1'b1};

    model_reset();
    do_reset();
    chk("rst_saldo", saldo_o, 5);
    chk("rst_tempo", tempo_o, 0);
    chk("rst_auth", auth_o, 0);
    chk("rst_cout", cout_o, 0);

    // Login edge carries a deposit request that must be ignored
    op  = 1'b0;
    val = 4'd3;
    login();
    chk("login_auth", auth_o, 1);
    chk("login_no_tx", saldo_o, 5);
    cycle();
    chk("tempo_count", tempo_o, 2);

    foreach (vecs[i]) begin
      op  = vecs[i].op;
      val = vecs[i].val;
      cin = vecs[i].cin;
      press();
      chk({vecs[i].name, "_saldo"}, saldo_o, vecs[i].exp_saldo);
      chk({vecs[i].name, "_cout"}, cout_o, vecs[i].exp_cout);
    end

    // Holding Seleciona yields a single withdrawal of 2
    op  = 1'b1;
    val = 4'd2;
    cin = 1'b0;
    sel = 1'b1;
    repeat (5) cycle();
    sel = 1'b0;
    cycle();
    chk("hold_one_tx", saldo_o, 13);

    // Exit beats a same-cycle transaction
    en  = 1'b0;
    sel = 1'b1;
    cycle();
    sel = 1'b0;
    chk("exit_auth", auth_o, 0);
    chk("exit_drop_tx", saldo_o, 13);
    cycle();

    // Timeout: count edges after login until logout
    login();
    val = 4'd0;
    n = 1;
    while (auth_o && n < 600) begin
      cycle();
      n++;
    end
    chk("timeout_edges", n, TIMEOUT);
    chk("timeout_tempo", tempo_o, 0);

    // Balance persists across sessions
    login();
    chk("persist_saldo", saldo_o, 13);

    // Reset mid-session restores the balance
    do_reset();
    chk("midrst_saldo", saldo_o, 5);
    chk("midrst_auth", auth_o, 0);

    // Bad logins, then a correct one
    cod = 5'b11111;
    pin = 4'b0000;
    en  = 1'b1;
    repeat (3) press();
    chk("bad_login", auth_o, 0);
    login();
`ifdef ESQUEMA_LOCKOUT_EN
    chk("locked_login", auth_o, 0);
`else
    chk("retry_login", auth_o, 1);
`endif
    do_reset();

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 49) != 0);
      sel = $urandom_range(0, 1);
      op  = $urandom_range(0, 1);
      cin = $urandom_range(0, 1);
      val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        cod = 5'b10000;
        pin = 4'b1001;
      end else begin
        cod = 5'($urandom_range(0, 31));
        pin = 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
